// File: rtl/fetch_decode_buffer.sv
// Fetch/decode pipeline register: joins opcode+immediate pairs into one packet, one-cycle latency.
// Backpressure: stall freezes every register and ignores the input; flush drops any partial instruction.
module fetch_decode_buffer #(
   parameter int                 ADDR_W   = 32,
   parameter int                 INSTR_W  = 16,
   parameter int                 LONG_BIT = 0,
   parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic               in_valid,
   input  logic               stall,
   input  logic               flush,
   output logic [INSTR_W-1:0] instr_out,
   output logic [INSTR_W-1:0] imm_out,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               valid_out,
   output logic               imm_pending
);

   localparam logic [0:0] S_FIRST = 1'b0;
   localparam logic [0:0] S_IMM   = 1'b1;

   logic [0:0]         state;
   logic [INSTR_W-1:0] hold_instr;
   logic [ADDR_W-1:0]  hold_pc;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state       <= S_FIRST;
         instr_out   <= NOP_WORD;
         imm_out     <= '0;
         pc_out      <= '0;
         valid_out   <= 1'b0;
         hold_instr  <= '0;
         hold_pc     <= '0;
         imm_pending <= 1'b0;
      end else if (!stall) begin
         case (state)
            S_FIRST: begin
               if (!in_valid) begin
                  valid_out <= 1'b0;
                  instr_out <= NOP_WORD;
                  imm_out   <= '0;
               end else if (!instr_in[LONG_BIT]) begin
                  instr_out <= instr_in;
                  pc_out    <= pc_in;
                  imm_out   <= '0;
                  valid_out <= 1'b1;
               end else begin
                  // Opcode of a two-word instruction: park it and emit a bubble.
                  hold_instr  <= instr_in;
                  hold_pc     <= pc_in;
                  valid_out   <= 1'b0;
                  instr_out   <= NOP_WORD;
                  state       <= S_IMM;
                  imm_pending <= 1'b1;
               end
            end
            S_IMM: begin
               if (!in_valid) begin
                  valid_out <= 1'b0;
               end else begin
                  // Immediate word is pure data; its LONG_BIT is not looked at.
                  instr_out   <= hold_instr;
                  pc_out      <= hold_pc;
                  imm_out     <= instr_in;
                  valid_out   <= 1'b1;
                  state       <= S_FIRST;
                  imm_pending <= 1'b0;
               end
            end
            default: begin
               state       <= S_FIRST;
               imm_pending <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer: reset, short/long instructions, gaps, stall and flush.
module tb_fetch_decode_buffer;

   logic        clk;
   logic        rst;
   logic [15:0] instr_in;
   logic [31:0] pc_in;
   logic        in_valid;
   logic        stall;
   logic        flush;
   logic [15:0] instr_out;
   logic [15:0] imm_out;
   logic [31:0] pc_out;
   logic        valid_out;
   logic        imm_pending;

   int n_checks;
   int n_fail;

   fetch_decode_buffer dut (
      .clk         (clk),
      .rst         (rst),
      .instr_in    (instr_in),
      .pc_in       (pc_in),
      .in_valid    (in_valid),
      .stall       (stall),
      .flush       (flush),
      .instr_out   (instr_out),
      .imm_out     (imm_out),
      .pc_out      (pc_out),
      .valid_out   (valid_out),
      .imm_pending (imm_pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] w, input logic [31:0] pc);
      in_valid = v;
      instr_in = w;
      pc_in    = pc;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 16'h0070, 32'h20);
      step();
      step();
      n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %h exp 0", valid_out); end
      n_checks++; if (instr_out !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h exp 0000", instr_out); end
      n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc_out); end
      n_checks++; if (imm_out !== 16'h0000) begin n_fail++; $display("FAIL reset_imm got %h exp 0000", imm_out); end
      n_checks++; if (imm_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %h exp 0", imm_pending); end
      rst = 1'b0;
      step();
      n_checks++; if (instr_out !== 16'h0070 || pc_out !== 32'h20 || valid_out !== 1'b1)
         begin n_fail++; $display("FAIL post_reset got %h/%h/%b exp 0070/20/1", instr_out, pc_out, valid_out); end
   endtask

   task automatic test_short_stream();
      logic [15:0] words [3];
      words[0] = 16'h0070; words[1] = 16'h0072; words[2] = 16'h0074;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, words[i], 32'h20 + 32'(i));
         step();
         n_checks++; if (instr_out !== words[i] || pc_out !== 32'h20 + 32'(i) || imm_out !== 16'h0 || valid_out !== 1'b1)
            begin n_fail++; $display("FAIL short_%0d got %h/%h/%h/%b exp %h/%h/0000/1", i, instr_out, pc_out, imm_out, valid_out, words[i], 32'h20 + 32'(i)); end
      end
      drive(1'b0, 16'hFFFF, 32'h99);
      step();
      n_checks++; if (valid_out !== 1'b0 || instr_out !== 16'h0000 || pc_out !== 32'h22)
         begin n_fail++; $display("FAIL short_idle got %b/%h/%h exp 0/0000/22", valid_out, instr_out, pc_out); end
   endtask

   task automatic test_long();
      drive(1'b1, 16'h0071, 32'h20);
      step();
      n_checks++; if (valid_out !== 1'b0 || imm_pending !== 1'b1 || instr_out !== 16'h0000)
         begin n_fail++; $display("FAIL long_first got %b/%b/%h exp 0/1/0000", valid_out, imm_pending, instr_out); end
      drive(1'b1, 16'hBEEF, 32'h21);
      step();
      n_checks++; if (instr_out !== 16'h0071 || imm_out !== 16'hBEEF || pc_out !== 32'h20 || valid_out !== 1'b1 || imm_pending !== 1'b0)
         begin n_fail++; $display("FAIL long_pkt got %h/%h/%h/%b/%b exp 0071/beef/20/1/0", instr_out, imm_out, pc_out, valid_out, imm_pending); end
   endtask

   task automatic test_gap();
      drive(1'b1, 16'h0071, 32'h20);
      step();
      drive(1'b0, 16'h0000, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (imm_pending !== 1'b1 || valid_out !== 1'b0)
            begin n_fail++; $display("FAIL gap_%0d got pend %b valid %b exp 1/0", i, imm_pending, valid_out); end
      end
      drive(1'b1, 16'h1234, 32'h24);
      step();
      n_checks++; if (instr_out !== 16'h0071 || imm_out !== 16'h1234 || pc_out !== 32'h20 || valid_out !== 1'b1 || imm_pending !== 1'b0)
         begin n_fail++; $display("FAIL gap_pkt got %h/%h/%h/%b/%b exp 0071/1234/20/1/0", instr_out, imm_out, pc_out, valid_out, imm_pending); end
   endtask

   task automatic test_stall();
      drive(1'b1, 16'h0072, 32'h21);
      step();
      stall = 1'b1;
      drive(1'b1, 16'h0074, 32'h22);
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++; if (instr_out !== 16'h0072 || pc_out !== 32'h21 || valid_out !== 1'b1)
            begin n_fail++; $display("FAIL stall_%0d got %h/%h/%b exp 0072/21/1", i, instr_out, pc_out, valid_out); end
      end
      stall = 1'b0;
      step();
      n_checks++; if (instr_out !== 16'h0074 || pc_out !== 32'h22 || valid_out !== 1'b1)
         begin n_fail++; $display("FAIL stall_release got %h/%h/%b exp 0074/22/1", instr_out, pc_out, valid_out); end
      // Stall while waiting for an immediate must not consume the word.
      drive(1'b1, 16'h0071, 32'h30);
      step();
      stall = 1'b1;
      drive(1'b1, 16'h5555, 32'h31);
      step();
      n_checks++; if (imm_pending !== 1'b1 || valid_out !== 1'b0)
         begin n_fail++; $display("FAIL stall_imm got pend %b valid %b exp 1/0", imm_pending, valid_out); end
      stall = 1'b0;
      step();
      n_checks++; if (instr_out !== 16'h0071 || imm_out !== 16'h5555 || pc_out !== 32'h30 || valid_out !== 1'b1)
         begin n_fail++; $display("FAIL stall_imm_pkt got %h/%h/%h/%b exp 0071/5555/30/1", instr_out, imm_out, pc_out, valid_out); end
   endtask

   task automatic test_flush();
      drive(1'b1, 16'h0071, 32'h20);
      step();
      n_checks++; if (imm_pending !== 1'b1)
         begin n_fail++; $display("FAIL flush_setup got pend %b exp 1", imm_pending); end
      flush = 1'b1; stall = 1'b1;
      drive(1'b1, 16'hAAAA, 32'h21);
      step();
      n_checks++; if (valid_out !== 1'b0 || imm_pending !== 1'b0 || instr_out !== 16'h0000 || pc_out !== 32'h0 || imm_out !== 16'h0)
         begin n_fail++; $display("FAIL flush got %b/%b/%h/%h/%h exp 0/0/0000/0/0000", valid_out, imm_pending, instr_out, pc_out, imm_out); end
      flush = 1'b0; stall = 1'b0;
      drive(1'b1, 16'h0072, 32'h21);
      step();
      n_checks++; if (instr_out !== 16'h0072 || pc_out !== 32'h21 || imm_out !== 16'h0 || valid_out !== 1'b1 || imm_pending !== 1'b0)
         begin n_fail++; $display("FAIL flush_after got %h/%h/%h/%b/%b exp 0072/21/0000/1/0", instr_out, pc_out, imm_out, valid_out, imm_pending); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_short_stream();
      test_long();
      test_gap();
      test_stall();
      test_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
